// File: rtl/or_nway_pipe.sv
// Pipelined N-way OR/AND reduction tree, one register stage per tree level, valid/ready handshake.
// Optional sticky result accumulator enabled by defining OR_NWAY_STICKY_EN.
module or_nway_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clear,
    output logic             sticky
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int PAD    = 1 << LEVELS;

    // Result bit j comes from source bits 2j and 2j+1. Bits at or above PAD/2
    // are forced to 0, so the final stage only ever has bit 0 set.
    function automatic logic [PAD-1:0] reduce_pairs(input logic [PAD-1:0] src, input logic md);
        logic [PAD-1:0] r;
        r = '0;
        for (int j = 0; j < PAD / 2; j++) begin
            r[j] = md ? (src[2*j] & src[2*j+1]) : (src[2*j] | src[2*j+1]);
        end
        return r;
    endfunction

    logic [PAD-1:0]    data_q [LEVELS];
    logic [PAD-1:0]    data_d [LEVELS];
    logic [LEVELS-1:0] valid_q, valid_d;
    logic [LEVELS-1:0] mode_q, mode_d;
    logic [PAD-1:0]    leaves;
    logic              advance;
    logic              unused_last_mode;

    always_comb begin
        advance = !valid_q[LEVELS-1] || out_ready;
        // Unused leaves take the identity value of the selected reduction.
        leaves              = {PAD{mode}};
        leaves[WIDTH-1:0]   = x;
        // Bubbles carry zero data so out stays 0 whenever out_valid is low.
        if (!in_valid) begin
            leaves = '0;
        end
        data_d  = data_q;
        valid_d = valid_q;
        mode_d  = mode_q;
        if (advance) begin
            data_d[0]  = reduce_pairs(leaves, mode);
            valid_d[0] = in_valid;
            mode_d[0]  = mode;
            for (int k = 1; k < LEVELS; k++) begin
                data_d[k]  = reduce_pairs(data_q[k-1], mode_q[k-1]);
                valid_d[k] = valid_q[k-1];
                mode_d[k]  = mode_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            mode_q  <= '0;
            for (int k = 0; k < LEVELS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign in_ready         = advance;
    assign out_valid        = valid_q[LEVELS-1];
    assign out              = |data_q[LEVELS-1];
    assign unused_last_mode = mode_q[LEVELS-1];

`ifdef OR_NWAY_STICKY_EN
    logic sticky_q, sticky_d;
    logic consume;

    always_comb begin
        consume  = out_valid && out_ready;
        sticky_d = sticky_q;
        if (clear) begin
            sticky_d = consume ? out : 1'b0;
        end else if (consume) begin
            sticky_d = sticky_q | out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_or_nway_pipe.sv
// Self-checking bench for or_nway_pipe: directed latency/stall/reset/sticky sequences plus
// randomized traffic against an in-order scoreboard of reduction results.
module tb_or_nway_pipe;

    localparam int LEV16 = 4;
`ifdef OR_NWAY_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] x;
    logic        mode, in_valid, in_ready, out, out_valid, out_ready, clear, sticky;

    logic [9:0]  x10;
    logic        mode10, in_valid10, in_ready10, out10, out_valid10, out_ready10, clear10, sticky10;

    or_nway_pipe #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .x(x), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .clear(clear), .sticky(sticky)
    );

    or_nway_pipe #(.WIDTH(10)) dut10 (
        .clk(clk), .reset(reset), .x(x10), .mode(mode10), .in_valid(in_valid10),
        .in_ready(in_ready10), .out(out10), .out_valid(out_valid10), .out_ready(out_ready10),
        .clear(clear10), .sticky(sticky10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_pass = 0;
    int  n_tot  = 0;
    int  n_cons = 0;
    bit  exp_q[$];
    bit  st_exp = 1'b0;
    bit  st_chk_en = 1'b0;
    bit  prev_stall = 1'b0;
    logic prev_out;
    logic s_out, s_ov, s_ir, s_st;
    bit  s_acc;

    typedef struct {
        logic [15:0] vx;
        bit          vm;
        bit          ve;
    } vec_t;

    typedef struct {
        logic [9:0] vx;
        bit         vm;
        bit         ve;
    } vec10_t;

    function automatic bit ref_red16(logic [15:0] v, bit m);
        return m ? (v == 16'hFFFF) : (v != 16'h0000);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    endtask

    // One clock of the 16-bit DUT: drive inputs after negedge, sample, update scoreboard.
    task automatic step(bit iv, logic [15:0] ix, bit im, bit ordy, bit iclr, bit irst);
        bit cons;
        bit e;
        @(negedge clk);
        in_valid = iv; x = ix; mode = im; out_ready = ordy; clear = iclr; reset = irst;
        #1;
        s_out = out; s_ov = out_valid; s_ir = in_ready; s_st = sticky;
        if (st_chk_en) chk("sticky", sticky, st_exp);
        if (prev_stall) begin
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_out", out, prev_out);
        end
        prev_stall = (out_valid === 1'b1) && !ordy && !irst;
        prev_out   = out;
        s_acc      = 1'b0;
        e          = 1'b0;
        if (irst) begin
            exp_q.delete();
            st_exp    = 1'b0;
            st_chk_en = 1'b1;
        end else begin
            cons = (out_valid === 1'b1) && ordy;
            if (cons) begin
                n_cons++;
                if (exp_q.size() == 0) chk("unexpected_result", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("result", out, e);
                end
            end
`ifdef OR_NWAY_STICKY_EN
            if (iclr) st_exp = cons ? e : 1'b0;
            else if (cons) st_exp = st_exp | e;
`endif
            if (iv && in_ready === 1'b1) begin
                s_acc = 1'b1;
                exp_q.push_back(ref_red16(ix, im));
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 1, 0, 0);
    endtask

    initial begin
        vec_t   tv[6];
        vec10_t tv10[4];
        logic   held_out;
        int     idx, cons0;
        logic [15:0] sx[8];

        tv[0] = '{16'h0000, 1'b0, 1'b0};
        tv[1] = '{16'h0100, 1'b0, 1'b1};
        tv[2] = '{16'hFFFF, 1'b1, 1'b1};
        tv[3] = '{16'hFFFE, 1'b1, 1'b0};
        tv[4] = '{16'h8000, 1'b0, 1'b1};
        tv[5] = '{16'h7FFF, 1'b1, 1'b0};
        tv10[0] = '{10'h3FF, 1'b1, 1'b1};
        tv10[1] = '{10'h000, 1'b0, 1'b0};
        tv10[2] = '{10'h1FF, 1'b1, 1'b0};
        tv10[3] = '{10'h200, 1'b0, 1'b1};

        x10 = '0; mode10 = 0; in_valid10 = 0; out_ready10 = 1; clear10 = 0;
        x = '0; mode = 0; in_valid = 0; out_ready = 1; clear = 0; reset = 1;

        // Reset state
        step(0, 16'h0, 0, 1, 0, 1);
        step(0, 16'h0, 0, 1, 0, 1);
        chk("rst_in_ready_during", s_ir, 1);
        step(0, 16'h0, 0, 1, 0, 0);
        chk("rst_out_valid", s_ov, 0);
        chk("rst_out", s_out, 0);
        chk("rst_in_ready_after", s_ir, 1);
        chk("rst_sticky", s_st, 0);

        // Single beats: result visible exactly LEVELS cycles after acceptance
        for (int i = 0; i < 6; i++) begin
            step(1, tv[i].vx, tv[i].vm, 1, 0, 0);
            idle(LEV16 - 1);
            step(0, 16'h0, 0, 1, 0, 0);
            chk("lat_valid", s_ov, 1);
            chk("lat_out", s_out, tv[i].ve);
        end
        idle(2);

        // Back-to-back OR then AND pairs
        step(1, 16'h0000, 0, 1, 0, 0);
        step(1, 16'h0100, 0, 1, 0, 0);
        idle(2);
        step(0, 16'h0, 0, 1, 0, 0);
        chk("b2b_or_v0", s_ov, 1); chk("b2b_or_o0", s_out, 0);
        step(0, 16'h0, 0, 1, 0, 0);
        chk("b2b_or_v1", s_ov, 1); chk("b2b_or_o1", s_out, 1);
        step(1, 16'hFFFF, 1, 1, 0, 0);
        step(1, 16'hFFFE, 1, 1, 0, 0);
        idle(2);
        step(0, 16'h0, 0, 1, 0, 0);
        chk("b2b_and_v0", s_ov, 1); chk("b2b_and_o0", s_out, 1);
        step(0, 16'h0, 0, 1, 0, 0);
        chk("b2b_and_v1", s_ov, 1); chk("b2b_and_o1", s_out, 0);
        idle(3);

        // WIDTH=10 padding and latency
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x10 = tv10[i].vx; mode10 = tv10[i].vm; in_valid10 = 1;
            @(negedge clk);
            in_valid10 = 0;
            repeat (3) @(negedge clk);
            #1;
            chk("w10_valid", out_valid10, 1);
            chk("w10_out", out10, tv10[i].ve);
        end

        // 8-beat stream with consumer stall in cycles 5..7
        for (int i = 0; i < 8; i++) sx[i] = (i % 3 == 0) ? 16'h0 : (16'h1 << i);
        idx = 0; cons0 = n_cons; held_out = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(idx < 8, (idx < 8) ? sx[idx] : 16'h0, 0, !(c >= 5 && c <= 7), 0, 0);
            if (s_acc) idx++;
            if (c >= 5 && c <= 7) begin
                chk("stall_in_ready", s_ir, 0);
                chk("stall_out_valid", s_ov, 1);
                if (c == 5) held_out = s_out;
                else chk("stall_out_stable", s_out, held_out);
            end
        end
        chk("stream_accepted", 64'(idx), 8);
        chk("stream_consumed", 64'(n_cons - cons0), 8);
        chk("stream_drained", 64'(exp_q.size()), 0);

        // Sticky: consume 0,1,0 then clear together with consuming a 0
        step(0, 16'h0, 0, 1, 1, 0);
        step(1, 16'h0000, 0, 1, 0, 0);
        step(1, 16'h0010, 0, 1, 0, 0);
        step(1, 16'h0000, 0, 1, 0, 0);
        idle(4);
        step(0, 16'h0, 0, 1, 0, 0);
        chk("sticky_after_010", s_st, STK);
        step(1, 16'h0000, 0, 1, 0, 0);
        idle(3);
        step(0, 16'h0, 0, 1, 1, 0);
        step(0, 16'h0, 0, 1, 0, 0);
        chk("sticky_clear_consume0", s_st, 0);

        // Reset with 3 beats in flight
        step(1, 16'h0001, 0, 1, 0, 0);
        idle(LEV16);
        step(1, 16'h0002, 0, 1, 0, 0);
        step(1, 16'h0004, 0, 1, 0, 0);
        step(1, 16'h0008, 0, 1, 0, 0);
        step(0, 16'h0, 0, 1, 0, 1);
        step(0, 16'h0, 0, 1, 0, 0);
        chk("midrst_out_valid", s_ov, 0);
        chk("midrst_sticky", s_st, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 16'h0, 0, 1, 0, 0);
            chk("midrst_no_stale", s_ov, 0);
        end

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 800; i++) begin
            logic [15:0] rx;
            int sel, sh;
            sel = int'($urandom_range(0, 7));
            sh  = int'($urandom_range(0, 15));
            case (sel)
                0: rx = 16'h0000;
                1: rx = 16'hFFFF;
                2: rx = 16'h1 << sh;
                3: rx = ~(16'h1 << sh);
                default: rx = 16'($urandom);
            endcase
            step($urandom_range(0, 9) < 7, rx, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 149) == 0);
        end
        idle(LEV16 + 2);
        chk("final_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
